// File: rtl/mdu_seq.sv
// RV64M multiply/divide sequencer: radix-2 shift-add multiplier and restoring divider
// driven by one FSM; one op in flight, result held until the consumer accepts it.
module mdu_seq #(
   parameter int XLEN  = 64,
   parameter int CNT_W = 7
) (
   input  logic            clk,
   input  logic            resetn,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [3:0]      op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   input  logic            flush,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] c
);
   localparam int HALF = XLEN / 2;
   localparam logic [CNT_W-1:0] ITER_D = CNT_W'(XLEN - 1);
   localparam logic [CNT_W-1:0] ITER_W = CNT_W'(HALF - 1);
   localparam logic [XLEN-1:0]  SMIN   = {1'b1, {(XLEN-1){1'b0}}};
   localparam logic [HALF-1:0]  SMIN_W = {1'b1, {(HALF-1){1'b0}}};

   typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;
   state_t state, state_nx;

   logic d_mul, d_div, d_w, d_rem, d_hi, d_as, d_bs, d_sdiv;
   logic [XLEN-1:0] a_ext, b_ext, a_mag, b_mag, a_sx, spec_res;
   logic a_neg, b_neg, div_zero, ovf, special, accept;

   logic [CNT_W-1:0]  cnt;
   logic [2*XLEN-1:0] prod, prod_step, prod_n;
   logic [XLEN-1:0]   mcand, divisor, quo, rem, rem_diff, sel, sel_n, fix_res, c_q;
   logic [XLEN:0]     mul_sum, rem_sh;
   logic [HALF-1:0]   mw;
   logic              div_ge, mul_q, w_q, rem_q, hi_q, neg_q;

   always_comb begin
      d_sdiv = (op == 4'd4) || (op == 4'd6) || (op == 4'd9) || (op == 4'd11);
      d_mul  = (op <= 4'd3) || (op == 4'd8);
      d_div  = ((op >= 4'd4) && (op <= 4'd7)) || ((op >= 4'd9) && (op <= 4'd12));
      d_w    = (op >= 4'd8) && (op <= 4'd12);
      d_rem  = (op == 4'd6) || (op == 4'd7) || (op == 4'd11) || (op == 4'd12);
      d_hi   = (op >= 4'd1) && (op <= 4'd3);
      d_as   = (op == 4'd1) || (op == 4'd2) || d_sdiv;
      d_bs   = (op == 4'd1) || d_sdiv;
   end

   // Operands are reduced to magnitudes here; the sign is re-applied in FIX.
   always_comb begin
      a_sx  = {{HALF{a[HALF-1]}}, a[HALF-1:0]};
      a_ext = a;
      b_ext = b;
      if (d_w) begin
         a_ext = d_as ? a_sx : {{HALF{1'b0}}, a[HALF-1:0]};
         b_ext = d_bs ? {{HALF{b[HALF-1]}}, b[HALF-1:0]} : {{HALF{1'b0}}, b[HALF-1:0]};
      end
      a_neg    = d_as & a_ext[XLEN-1];
      b_neg    = d_bs & b_ext[XLEN-1];
      a_mag    = a_neg ? -a_ext : a_ext;
      b_mag    = b_neg ? -b_ext : b_ext;
      div_zero = d_w ? (b[HALF-1:0] == '0) : (b == '0);
      ovf      = d_sdiv && (d_w ? ((a[HALF-1:0] == SMIN_W) && (b[HALF-1:0] == '1))
                                : ((a == SMIN) && (b == '1)));
      special  = !d_mul && (!d_div || div_zero || ovf);
      spec_res = '0;
      if (d_div && div_zero)
         spec_res = d_rem ? (d_w ? a_sx : a) : '1;
      else if (d_div && ovf)
         spec_res = d_rem ? '0 : (d_w ? a_sx : a);
   end

   // valid/ready: an op transfers on a rising edge where in_valid && in_ready;
   // a result transfers where out_valid && out_ready. flush blocks acceptance.
   assign in_ready  = (state == S_IDLE) && !flush;
   assign out_valid = (state == S_DONE);
   assign accept    = in_valid && in_ready;
   assign c         = c_q;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state <= S_IDLE;
      else         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      if (flush) begin
         state_nx = S_IDLE;
      end else begin
         case (state)
            S_IDLE: begin
               if (accept) begin
                  if (d_mul)        state_nx = S_MUL;
                  else if (special) state_nx = S_DONE;
                  else              state_nx = S_DIV;
               end
            end
            S_MUL, S_DIV: if (cnt == '0) state_nx = S_FIX;
            S_FIX:        state_nx = S_DONE;
            S_DONE:       if (out_ready) state_nx = S_IDLE;
            default:      state_nx = S_IDLE;
         endcase
      end
   end

   // W multiplies run 32 steps, leaving the product at prod[95:32].
   always_comb begin
      mul_sum   = {1'b0, prod[2*XLEN-1:XLEN]} + {1'b0, mcand};
      prod_step = prod[0] ? {mul_sum, prod[XLEN-1:1]} : {1'b0, prod[2*XLEN-1:1]};
      rem_sh    = {rem, quo[XLEN-1]};
      div_ge    = rem_sh >= {1'b0, divisor};
      rem_diff  = rem_sh[XLEN-1:0] - divisor;
      prod_n    = neg_q ? -prod : prod;
      mw        = prod[XLEN-1:HALF];
      sel       = rem_q ? rem : quo;
      sel_n     = neg_q ? -sel : sel;
      if (mul_q) begin
         if (hi_q)     fix_res = prod_n[2*XLEN-1:XLEN];
         else if (w_q) fix_res = {{HALF{mw[HALF-1]}}, mw};
         else          fix_res = prod_n[XLEN-1:0];
      end else if (w_q) begin
         fix_res = {{HALF{sel_n[HALF-1]}}, sel_n[HALF-1:0]};
      end else begin
         fix_res = sel_n;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cnt     <= '0;
         prod    <= '0;
         mcand   <= '0;
         divisor <= '0;
         quo     <= '0;
         rem     <= '0;
         c_q     <= '0;
         mul_q   <= 1'b0;
         w_q     <= 1'b0;
         rem_q   <= 1'b0;
         hi_q    <= 1'b0;
         neg_q   <= 1'b0;
      end else begin
         if (accept) begin
            mul_q   <= d_mul;
            w_q     <= d_w;
            rem_q   <= d_rem;
            hi_q    <= d_hi;
            neg_q   <= d_rem ? a_neg : (a_neg ^ b_neg);
            cnt     <= d_w ? ITER_W : ITER_D;
            mcand   <= a_mag;
            divisor <= b_mag;
            prod    <= {{XLEN{1'b0}}, b_mag};
            quo     <= d_w ? {a_mag[HALF-1:0], {HALF{1'b0}}} : a_mag;
            rem     <= '0;
            if (special) c_q <= spec_res;
         end
         case (state)
            S_MUL: begin
               prod <= prod_step;
               if (cnt != '0) cnt <= cnt - CNT_W'(1);
            end
            S_DIV: begin
               rem <= div_ge ? rem_diff : rem_sh[XLEN-1:0];
               quo <= {quo[XLEN-2:0], div_ge};
               if (cnt != '0) cnt <= cnt - CNT_W'(1);
            end
            S_FIX:   if (!flush) c_q <= fix_res;
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_mdu_seq.sv
// Self-checking bench for mdu_seq: directed table, randomized ops against an
// arithmetic reference model, hold, flush and asynchronous reset scenarios.
module tb_mdu_seq;
   logic        clk, resetn, in_valid, in_ready, flush, out_valid, out_ready;
   logic [3:0]  op;
   logic [63:0] a, b, c;

   int n_vec = 0;
   int n_err = 0;
   logic [63:0] exp_q[$];
   int          lat_q[$];

   typedef struct {
      logic [3:0]  o;
      logic [63:0] x;
      logic [63:0] y;
      logic [63:0] e;
      int          l;
   } vec_t;
   vec_t tbl[13];

   mdu_seq #(.XLEN(64), .CNT_W(7)) dut (
      .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
      .op(op), .a(a), .b(b), .flush(flush), .out_valid(out_valid),
      .out_ready(out_ready), .c(c)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // reference model
   function automatic logic [63:0] sext32(input logic [31:0] v);
      return {{32{v[31]}}, v};
   endfunction

   function automatic logic [63:0] model(input logic [3:0] o, input logic [63:0] x, input logic [63:0] y);
      logic [127:0] p;
      longint sx, sy;
      int sx32, sy32;
      logic [31:0] ux32, uy32, r32;
      logic ovf64, ovf32;
      sx = x; sy = y;
      ux32 = x[31:0]; uy32 = y[31:0];
      sx32 = ux32; sy32 = uy32;
      ovf64 = (x == 64'h8000_0000_0000_0000) && (y == 64'hFFFF_FFFF_FFFF_FFFF);
      ovf32 = (ux32 == 32'h8000_0000) && (uy32 == 32'hFFFF_FFFF);
      case (o)
         4'd0: return x * y;
         4'd1: begin p = {{64{x[63]}}, x} * {{64{y[63]}}, y}; return p[127:64]; end
         4'd2: begin p = {{64{x[63]}}, x} * {64'd0, y}; return p[127:64]; end
         4'd3: begin p = {64'd0, x} * {64'd0, y}; return p[127:64]; end
         4'd4: begin
            if (y == 0) return 64'hFFFF_FFFF_FFFF_FFFF;
            if (ovf64) return x;
            return 64'(sx / sy);
         end
         4'd5: return (y == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : x / y;
         4'd6: begin
            if (y == 0) return x;
            if (ovf64) return 64'd0;
            return 64'(sx % sy);
         end
         4'd7: return (y == 0) ? x : x % y;
         4'd8: begin r32 = ux32 * uy32; return sext32(r32); end
         4'd9: begin
            if (uy32 == 0) return 64'hFFFF_FFFF_FFFF_FFFF;
            if (ovf32) return sext32(ux32);
            r32 = 32'(sx32 / sy32); return sext32(r32);
         end
         4'd10: begin
            if (uy32 == 0) return 64'hFFFF_FFFF_FFFF_FFFF;
            r32 = ux32 / uy32; return sext32(r32);
         end
         4'd11: begin
            if (uy32 == 0) return sext32(ux32);
            if (ovf32) return 64'd0;
            r32 = 32'(sx32 % sy32); return sext32(r32);
         end
         4'd12: begin
            if (uy32 == 0) return sext32(ux32);
            r32 = ux32 % uy32; return sext32(r32);
         end
         default: return 64'd0;
      endcase
   endfunction

   function automatic int exp_lat(input logic [3:0] o, input logic [63:0] x, input logic [63:0] y);
      if (o <= 4'd3) return 66;
      if (o == 4'd8) return 34;
      if (o >= 4'd13) return 1;
      if (o <= 4'd7) begin
         if (y == 0) return 1;
         if ((o == 4'd4 || o == 4'd6) && x == 64'h8000_0000_0000_0000 && y == 64'hFFFF_FFFF_FFFF_FFFF) return 1;
         return 66;
      end
      if (y[31:0] == 0) return 1;
      if ((o == 4'd9 || o == 4'd11) && x[31:0] == 32'h8000_0000 && y[31:0] == 32'hFFFF_FFFF) return 1;
      return 34;
   endfunction

   // driver tasks
   task automatic issue(input logic [3:0] o, input logic [63:0] x, input logic [63:0] y, output bit acc);
      @(negedge clk);
      op = o; a = x; b = y; in_valid = 1'b1;
      #1 acc = in_ready;
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic wait_out(output logic [63:0] res, output int lat, output bit tmo);
      lat = 1;
      while (out_valid !== 1'b1 && lat < 200) begin
         @(posedge clk);
         #1 lat++;
      end
      tmo = (out_valid !== 1'b1);
      res = c;
   endtask

   task automatic release_out();
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
   endtask

   // scenarios
   task automatic test_reset();
      #1;
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
      n_vec++; if (c !== 64'd0) begin n_err++; $display("FAIL reset_c: got %h want 0", c); end
      repeat (3) @(posedge clk);
      @(negedge clk) resetn = 1'b1;
   endtask

   task automatic test_directed();
      bit acc, tmo;
      int lat;
      logic [63:0] res;
      tbl[0]  = '{4'd0,  64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 66};
      tbl[1]  = '{4'd3,  64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 66};
      tbl[2]  = '{4'd4,  64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 66};
      tbl[3]  = '{4'd6,  64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 66};
      tbl[4]  = '{4'd5,  64'd7, 64'd2, 64'd3, 66};
      tbl[5]  = '{4'd7,  64'd7, 64'd2, 64'd1, 66};
      tbl[6]  = '{4'd4,  64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1};
      tbl[7]  = '{4'd6,  64'd5, 64'd0, 64'd5, 1};
      tbl[8]  = '{4'd4,  64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1};
      tbl[9]  = '{4'd6,  64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1};
      tbl[10] = '{4'd10, 64'h0000_0000_FFFF_FFFE, 64'd1, 64'hFFFF_FFFF_FFFF_FFFE, 34};
      tbl[11] = '{4'd8,  64'h0000_0001_0000_0003, 64'd2, 64'd6, 34};
      tbl[12] = '{4'd14, 64'd123, 64'd456, 64'd0, 1};
      for (int i = 0; i < 13; i++) begin
         issue(tbl[i].o, tbl[i].x, tbl[i].y, acc);
         n_vec++; if (acc !== 1'b1) begin n_err++; $display("FAIL dir_accept[%0d]: got %b want 1", i, acc); end
         wait_out(res, lat, tmo);
         n_vec++; if (tmo) begin n_err++; $display("FAIL dir_timeout[%0d]: out_valid never rose", i); end
         n_vec++; if (res !== tbl[i].e) begin n_err++; $display("FAIL dir_c[%0d]: got %h want %h", i, res, tbl[i].e); end
         n_vec++; if (lat != tbl[i].l) begin n_err++; $display("FAIL dir_latency[%0d]: got %0d want %0d", i, lat, tbl[i].l); end
         release_out();
      end
   endtask

   task automatic test_hold();
      bit acc, tmo;
      int lat;
      logic [63:0] res;
      issue(4'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, acc);
      wait_out(res, lat, tmo);
      n_vec++; if (tmo) begin n_err++; $display("FAIL hold_timeout: out_valid never rose"); end
      for (int k = 0; k < 5; k++) begin
         n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL hold_valid[%0d]: got %b want 1", k, out_valid); end
         n_vec++; if (c !== 64'hFFFF_FFFF_FFFF_FFFE) begin n_err++; $display("FAIL hold_c[%0d]: got %h want fffffffffffffffe", k, c); end
         n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL hold_in_ready[%0d]: got %b want 0", k, in_ready); end
         @(posedge clk);
         #1;
      end
      release_out();
      n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL hold_release_ready: got %b want 1", in_ready); end
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL hold_release_valid: got %b want 0", out_valid); end
   endtask

   task automatic test_back_to_back();
      bit acc, tmo;
      int lat;
      logic [63:0] res, e;
      logic [3:0]  ops[2];
      ops[0] = 4'd5; ops[1] = 4'd1;
      for (int i = 0; i < 2; i++) begin
         logic [63:0] x, y;
         x = {$urandom, $urandom};
         y = {$urandom, $urandom};
         exp_q.push_back(model(ops[i], x, y));
         issue(ops[i], x, y, acc);
         n_vec++; if (acc !== 1'b1) begin n_err++; $display("FAIL b2b_accept[%0d]: got %b want 1", i, acc); end
         wait_out(res, lat, tmo);
         e = exp_q.pop_front();
         n_vec++; if (tmo || res !== e) begin n_err++; $display("FAIL b2b_c[%0d]: got %h want %h (timeout %0d)", i, res, e, tmo); end
         release_out();
      end
   endtask

   task automatic test_random();
      bit acc, tmo;
      int lat, el, mode;
      logic [3:0]  o;
      logic [63:0] x, y, res, e;
      for (int i = 0; i < 60; i++) begin
         o = 4'($urandom_range(0, 15));
         x = {$urandom, $urandom};
         y = {$urandom, $urandom};
         mode = $urandom_range(0, 5);
         case (mode)
            0: y = x[0] ? 64'd0 : {$urandom, 32'd0};
            1: begin x = 64'h8000_0000_0000_0000; y = 64'hFFFF_FFFF_FFFF_FFFF; end
            2: begin
               x = 64'($urandom_range(0, 200)) - 64'd100;
               y = 64'($urandom_range(1, 20));
               if ($urandom_range(0, 1) == 1) y = -y;
            end
            3: begin x = {$urandom, 32'h8000_0000}; y = {$urandom, 32'hFFFF_FFFF}; end
            default: ;
         endcase
         exp_q.push_back(model(o, x, y));
         lat_q.push_back(exp_lat(o, x, y));
         issue(o, x, y, acc);
         n_vec++; if (acc !== 1'b1) begin n_err++; $display("FAIL rnd_accept[%0d]: got %b want 1", i, acc); end
         wait_out(res, lat, tmo);
         e  = exp_q.pop_front();
         el = lat_q.pop_front();
         n_vec++; if (tmo || res !== e) begin n_err++; $display("FAIL rnd_c[%0d] op %0d a %h b %h: got %h want %h", i, o, x, y, res, e); end
         n_vec++; if (lat != el) begin n_err++; $display("FAIL rnd_latency[%0d] op %0d: got %0d want %0d", i, o, lat, el); end
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
            n_vec++; if (out_valid !== 1'b1 || c !== e) begin n_err++; $display("FAIL rnd_hold[%0d]: valid %b c %h want 1 %h", i, out_valid, c, e); end
         end
         release_out();
      end
   endtask

   task automatic test_flush();
      bit acc;
      int n_valid, n_busy;
      logic [63:0] c_before;
      // flush at iteration 20 of a DIV, with a new request alongside
      issue(4'd4, 64'h1234_5678_9ABC_DEF0, 64'd3, acc);
      n_vec++; if (acc !== 1'b1) begin n_err++; $display("FAIL flush_accept: got %b want 1", acc); end
      c_before = c;
      repeat (19) @(posedge clk);
      @(negedge clk);
      flush = 1'b1; in_valid = 1'b1; op = 4'd5; a = 64'd100; b = 64'd7;
      #1;
      n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL flush_busy_ready: got %b want 0", in_ready); end
      @(posedge clk);
      #1 flush = 1'b0; in_valid = 1'b0;
      #1;
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_div_valid: got %b want 0", out_valid); end
      n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL flush_div_ready: got %b want 1", in_ready); end
      n_vec++; if (c !== c_before) begin n_err++; $display("FAIL flush_div_c: got %h want %h", c, c_before); end
      n_valid = 0; n_busy = 0;
      for (int k = 0; k < 80; k++) begin
         @(posedge clk);
         #1;
         if (out_valid === 1'b1) n_valid++;
         if (in_ready !== 1'b1) n_busy++;
      end
      n_vec++; if (n_valid != 0) begin n_err++; $display("FAIL flush_no_output: got %0d valid cycles want 0", n_valid); end
      n_vec++; if (n_busy != 0) begin n_err++; $display("FAIL flush_no_accept: got %0d busy cycles want 0", n_busy); end

      // flush in IDLE beats a same-cycle handshake
      @(negedge clk);
      flush = 1'b1; in_valid = 1'b1; op = 4'd4; a = 64'd5; b = 64'd0;
      @(posedge clk);
      #1 flush = 1'b0; in_valid = 1'b0;
      n_valid = 0;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk);
         #1;
         if (out_valid === 1'b1) n_valid++;
      end
      n_vec++; if (n_valid != 0) begin n_err++; $display("FAIL flush_idle_accept: got %0d valid cycles want 0", n_valid); end
      n_vec++; if (c !== c_before) begin n_err++; $display("FAIL flush_idle_c: got %h want %h", c, c_before); end

      // flush in DONE beats out_ready; result value is retained
      issue(4'd4, 64'd5, 64'd0, acc);
      n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL flush_done_pre: got %b want 1", out_valid); end
      @(negedge clk);
      flush = 1'b1; out_ready = 1'b1;
      @(posedge clk);
      #1 flush = 1'b0; out_ready = 1'b0;
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_done_valid: got %b want 0", out_valid); end
      n_vec++; if (c !== 64'hFFFF_FFFF_FFFF_FFFF) begin n_err++; $display("FAIL flush_done_c: got %h want ffffffffffffffff", c); end
   endtask

   task automatic test_async_reset();
      bit acc;
      int n_valid;
      issue(4'd0, {$urandom, $urandom}, {$urandom, $urandom}, acc);
      n_vec++; if (acc !== 1'b1) begin n_err++; $display("FAIL areset_accept: got %b want 1", acc); end
      repeat (10) @(posedge clk);
      #3 resetn = 1'b0;
      #1;
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL areset_valid: got %b want 0", out_valid); end
      n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL areset_ready: got %b want 1", in_ready); end
      n_vec++; if (c !== 64'd0) begin n_err++; $display("FAIL areset_c: got %h want 0", c); end
      @(negedge clk) resetn = 1'b1;
      n_valid = 0;
      for (int k = 0; k < 80; k++) begin
         @(posedge clk);
         #1;
         if (out_valid === 1'b1) n_valid++;
      end
      n_vec++; if (n_valid != 0) begin n_err++; $display("FAIL areset_no_output: got %0d valid cycles want 0", n_valid); end
   endtask

   initial begin
      resetn = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
      op = 4'd0; a = 64'd0; b = 64'd0;
      test_reset();
      test_directed();
      test_hold();
      test_back_to_back();
      test_random();
      test_flush();
      test_async_reset();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
